// File: rtl/sccb_master.sv
// SCCB (OV7670) 3-phase write master: START, 27 bits {DEV_ADDR,X,reg_addr,X,reg_data,X}, STOP.
// Latency: start sampled in cycle T, done pulses in cycle T+114*Q+1, where Q = CLK_FREQ_HZ/(4*SCCB_FREQ_HZ).
// Backpressure: start is accepted only in IDLE; requests while busy (or during done) are dropped.
// Ports:
//   clk, rst       : rising-edge clock, synchronous active-high reset
//   start          : request a write of reg_data to reg_addr
//   reg_addr/data  : captured at accept, free to change afterwards
//   busy, done     : transaction in flight / one-cycle completion pulse
//   nack           : OR of the three don't-care-bit samples, valid with done
//   sioc           : SCCB clock, push-pull
//   siod_out/oe    : SIOD drive value and enable (pad = oe ? out : Z)
//   siod_in        : raw SIOD pin, synchronized internally
module sccb_master #(
  parameter int         CLK_FREQ_HZ  = 100_000_000,
  parameter int         SCCB_FREQ_HZ = 100_000,
  parameter logic [7:0] DEV_ADDR     = 8'h42
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] reg_addr,
  input  logic [7:0] reg_data,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic       sioc,
  output logic       siod_out,
  output logic       siod_oe,
  input  logic       siod_in
);

  localparam int Q  = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
  localparam int QW = (Q > 1) ? $clog2(Q) : 1;

  if (Q < 4) begin : g_q_too_small
    $error("sccb_master: quarter-bit period Q=%0d is below the minimum of 4", Q);
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BITS,
    S_STOP,
    S_DONE
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [QW-1:0]   qcnt;
  logic [1:0]      quarter;
  logic [4:0]      bit_cnt;
  logic [26:0]     shreg;
  logic            nack_r;
  logic            sync1;
  logic            sync2;

  logic            quarter_end;
  logic            bit_end;
  logic            dont_care;

  assign quarter_end = (qcnt == QW'(Q - 1));
  assign bit_end     = quarter_end && (quarter == 2'd3);
  // 0-based bit indices 8, 17 and 26 are the slave's don't-care slots.
  assign dont_care   = (bit_cnt == 5'd8) || (bit_cnt == 5'd17) || (bit_cnt == 5'd26);

  // State register plus the counters and datapath it sequences.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      qcnt    <= '0;
      quarter <= '0;
      bit_cnt <= '0;
      shreg   <= '1;
      nack_r  <= 1'b0;
      sync1   <= 1'b1;
      sync2   <= 1'b1;
    end else begin
      state <= next_state;
      sync1 <= siod_in;
      sync2 <= sync1;

      // Quarter timing restarts on every state change so each phase begins at q0.
      if (next_state != state || state == S_IDLE || state == S_DONE) begin
        qcnt    <= '0;
        quarter <= '0;
      end else if (quarter_end) begin
        qcnt    <= '0;
        quarter <= quarter + 2'd1;
      end else begin
        qcnt <= qcnt + QW'(1);
      end

      if (state == S_IDLE && start) begin
        shreg   <= {DEV_ADDR, 1'b1, reg_addr, 1'b1, reg_data, 1'b1};
        bit_cnt <= '0;
        nack_r  <= 1'b0;
      end else if (state == S_BITS && bit_end) begin
        shreg   <= {shreg[25:0], 1'b1};
        bit_cnt <= bit_cnt + 5'd1;
        if (dont_care) begin
          nack_r <= nack_r | sync2;
        end
      end
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_START;
      S_START: if (quarter_end && quarter == 2'd1) next_state = S_BITS;
      S_BITS:  if (bit_end && bit_cnt == 5'd26) next_state = S_STOP;
      S_STOP:  if (bit_end) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Output decode; bus idles high in IDLE and DONE.
  always_comb begin
    sioc     = 1'b1;
    siod_out = 1'b1;
    siod_oe  = 1'b1;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_START: begin
        busy     = 1'b1;
        siod_out = 1'b0;
      end
      S_BITS: begin
        busy     = 1'b1;
        sioc     = quarter[1];
        siod_out = shreg[26];
        siod_oe  = ~dont_care;
      end
      S_STOP: begin
        busy     = 1'b1;
        sioc     = (quarter != 2'd0);
        siod_out = quarter[1];
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign nack = nack_r;

endmodule

// File: tb/tb_sccb_master.sv
// Directed bench for sccb_master at CLK 4 MHz / SCCB 100 kHz (Q = 10, 1140-cycle transaction).
// A negedge monitor decodes SIOD at each SIOC rise, counts done pulses and watches bus conditions.
// All checks go through chk; one summary line at the end.
module tb_sccb_master;

  localparam int TXN = 1141;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] reg_addr = 8'h00;
  logic [7:0] reg_data = 8'h00;
  logic       busy, done, nack, sioc, siod_out, siod_oe;
  logic       siod_in = 1'b0;

  sccb_master #(
    .CLK_FREQ_HZ (4_000_000),
    .SCCB_FREQ_HZ(100_000),
    .DEV_ADDR    (8'h42)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .reg_addr(reg_addr),
    .reg_data(reg_data),
    .busy    (busy),
    .done    (done),
    .nack    (nack),
    .sioc    (sioc),
    .siod_out(siod_out),
    .siod_oe (siod_oe),
    .siod_in (siod_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic        line;
  logic        prev_line = 1'b1;
  logic        prev_sioc = 1'b1;
  logic        prev_busy = 1'b0;
  logic [26:0] cap_bits = '0;
  logic [26:0] cap_oe = '0;
  int          rises = 0;
  int          oe_low = 0;
  logic [26:0] last_bits = '0;
  logic [26:0] last_oe = '0;
  int          last_rises = 0;
  int          last_oe_low = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic        done_nack = 1'b0;
  int          start_conds = 0;
  int          viol = 0;

  always @(negedge clk) begin
    line = siod_oe ? siod_out : siod_in;
    if (busy && !prev_busy) begin
      rises  = 0;
      oe_low = 0;
    end
    if (busy && sioc && !prev_sioc) begin
      if (rises < 27) begin
        cap_bits = {cap_bits[25:0], line};
        cap_oe   = {cap_oe[25:0], siod_oe};
      end
      rises++;
    end
    if (busy && !siod_oe) oe_low++;
    // SIOD may only move under a high SIOC as a start (fall on accept) or stop (rise).
    if (!rst && prev_sioc && sioc && line != prev_line) begin
      if (!line && busy && !prev_busy) start_conds++;
      else if (!line) viol++;
    end
    if (done) begin
      done_cnt++;
      done_cyc    = cyc;
      done_nack   = nack;
      last_bits   = cap_bits;
      last_oe     = cap_oe;
      last_rises  = rises;
      last_oe_low = oe_low;
    end
    prev_line = line;
    prev_sioc = sioc;
    prev_busy = busy;
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_write(input logic [7:0] a, input logic [7:0] d, output int t);
    reg_addr = a;
    reg_data = d;
    start    = 1'b1;
    t        = cyc;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int n0, input int limit);
    int k;
    k = 0;
    while (done_cnt == n0 && k < limit) begin
      tick();
      k++;
    end
    chk({tag, "_done_seen"}, done_cnt - n0, 1);
  endtask

  task automatic check_txn(input string tag, input int t, input logic [26:0] exp_bits,
                           input logic exp_nack);
    chk({tag, "_latency"}, done_cyc - t, TXN);
    chk({tag, "_bits"}, last_bits, exp_bits);
    chk({tag, "_rises"}, last_rises, 28);
    chk({tag, "_oe_mask"}, last_oe, {8'hFF, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0});
    chk({tag, "_oe_low_cycles"}, last_oe_low, 120);
    chk({tag, "_nack"}, done_nack, exp_nack);
  endtask

  // ---------------- stimulus ----------------
  int t;
  int n0;
  int s0;
  int busy_low;

  initial begin
    repeat (3) tick();
    chk("reset_outputs", {sioc, siod_out, siod_oe, busy, done, nack}, 6'b111000);
    rst = 1'b0;
    repeat (3) tick();
    chk("idle_outputs", {sioc, siod_out, siod_oe, busy, done, nack}, 6'b111000);

    // Write 0x12 <- 0x80 with the slave pulling SIOD low; inputs scrambled after accept.
    siod_in = 1'b0;
    n0 = done_cnt;
    start_write(8'h12, 8'h80, t);
    reg_addr = 8'hFF;
    reg_data = 8'h00;
    chk("busy_after_accept", busy, 1'b1);
    wait_done("w1", n0, 1300);
    check_txn("w1", t, {8'h42, 1'b0, 8'h12, 1'b0, 8'h80, 1'b0}, 1'b0);
    tick();
    chk("w1_idle_after_done", {busy, done}, 2'b00);

    // Same write with SIOD floating high: don't-care slots read 1 and nack sets.
    siod_in = 1'b1;
    repeat (5) tick();
    n0 = done_cnt;
    start_write(8'h12, 8'h80, t);
    wait_done("w2", n0, 1300);
    check_txn("w2", t, {8'h42, 1'b1, 8'h12, 1'b1, 8'h80, 1'b1}, 1'b1);
    repeat (2) tick();
    siod_in = 1'b0;

    // Extra start pulse mid-transaction is ignored.
    repeat (5) tick();
    n0 = done_cnt;
    busy_low = 0;
    start_write(8'h12, 8'h80, t);
    while (cyc < t + 500) begin
      if (!busy) busy_low++;
      tick();
    end
    reg_addr = 8'h55;
    reg_data = 8'hAA;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    while (done_cnt == n0 && cyc < t + 1300) begin
      if (!busy) busy_low++;
      tick();
    end
    chk("w3_busy_held", busy_low, 0);
    repeat (30) tick();
    chk("w3_single_done", done_cnt - n0, 1);
    check_txn("w3", t, {8'h42, 1'b0, 8'h12, 1'b0, 8'h80, 1'b0}, 1'b0);

    // Reset mid-transaction aborts without done; following write is clean.
    n0 = done_cnt;
    start_write(8'h12, 8'h80, t);
    while (cyc < t + 600) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_bus_idle", {sioc, siod_out, busy, done, nack}, 5'b11000);
    repeat (50) tick();
    chk("abort_no_done", done_cnt - n0, 0);
    start_write(8'h11, 8'h01, t);
    wait_done("w4", n0, 1300);
    check_txn("w4", t, {8'h42, 1'b0, 8'h11, 1'b0, 8'h01, 1'b0}, 1'b0);

    // Back-to-back with start held high.
    repeat (5) tick();
    n0 = done_cnt;
    s0 = start_conds;
    reg_addr = 8'h3A;
    reg_data = 8'hC5;
    start    = 1'b1;
    t        = cyc;
    wait_done("b1", n0, 1300);
    check_txn("b1", t, {8'h42, 1'b0, 8'h3A, 1'b0, 8'hC5, 1'b0}, 1'b0);
    tick();
    chk("b2_idle_gap", busy, 1'b0);
    tick();
    chk("b2_accepted", busy, 1'b1);
    start = 1'b0;
    wait_done("b2", n0 + 1, 1300);
    chk("b2_latency", done_cyc - t, 2 * TXN + 1);
    chk("b2_bits", last_bits, {8'h42, 1'b0, 8'h3A, 1'b0, 8'hC5, 1'b0});
    chk("b2_start_conditions", start_conds - s0, 2);

    repeat (10) tick();
    chk("protocol_violations", viol, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sccb_master.md
SCCB_MASTER -- requirements
Module: sccb_master

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 100_000_000: system clock frequency.
REQ-002 SHALL have parameter SCCB_FREQ_HZ, default 100_000: SIOC bit rate.
REQ-003 SHALL have parameter DEV_ADDR, default 8'h42: OV7670 write ID byte, sent verbatim.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port start, input, 1: request a 3-phase write.
REQ-007 SHALL have port reg_addr, input, 8: camera register address.
REQ-008 SHALL have port reg_data, input, 8: value to write.
REQ-009 SHALL have port busy, output, 1: transaction in progress.
REQ-010 SHALL have port done, output, 1: one-cycle pulse at transaction end.
REQ-011 SHALL have port nack, output, 1: don't-care-bit status, valid while done=1.
REQ-012 SHALL have port sioc, output, 1: SCCB clock, driven push-pull.
REQ-013 SHALL have port siod_out, input side none; output, 1: SIOD drive value.
REQ-014 SHALL have port siod_oe, output, 1: SIOD drive enable (top ties cam_siod = oe ? out : Z).
REQ-015 SHALL have port siod_in, input, 1: sampled SIOD pin.

Function
REQ-016 SHALL derive Q = CLK_FREQ_HZ/(4*SCCB_FREQ_HZ), integer division; each quarter-bit lasts exactly Q clk cycles; Q < 4 is illegal (elaboration error).
REQ-017 SHALL use FSM states IDLE, START, BITS, STOP; DONE is a single-cycle pass back to IDLE.
REQ-018 IDLE: sioc=1, siod_oe=1, siod_out=1, busy=0; start=1 latches DEV_ADDR, reg_addr, reg_data into a 27-bit shift register {DEV_ADDR,X,reg_addr,X,reg_data,X} and enters START; busy=1 from the next cycle.
REQ-019 START (2 quarters): q0 siod_out=0 with sioc=1; q1 hold.
REQ-020 BITS: 27 bits, MSB first, 4 quarters each: q0 sioc=0 and siod_out updated; q1 sioc=0; q2 sioc=1; q3 sioc=1.
REQ-021 Bits 9, 18, 27 (don't-care): siod_oe=0 for all 4 quarters; otherwise siod_oe=1.
REQ-022 siod_in SHALL pass a 2-flop synchronizer; synchronized value sampled at the last cycle of q3 of each don't-care bit; nack = OR of the three samples, cleared at transaction accept.
REQ-023 STOP (4 quarters): q0 sioc=0 siod_out=0 oe=1; q1 sioc=1 siod_out=0; q2 sioc=1 siod_out=1; q3 hold (bus free).
REQ-024 Total duration 114*Q cycles: start sampled at cycle T, first START cycle T+1, done=1 and busy=0 in cycle T+114*Q+1.
REQ-025 start while busy=1 SHALL be ignored; no queuing; start in the same cycle as done is ignored (accepted only from IDLE).
REQ-026 reg_addr/reg_data changes after accept SHALL not affect the transaction in flight.
REQ-027 sioc SHALL change only at quarter boundaries; siod_out SHALL change only when sioc=0, except in START q0 and STOP q2.

Reset
REQ-028 rst=1 SHALL on the next edge force IDLE: sioc=1, siod_out=1, siod_oe=1, busy=0, done=0, nack=0, quarter and bit counters 0, synchronizer flops 1.
REQ-029 rst mid-transaction SHALL abort with no done pulse; bus returns to idle-high (SCCB slave tolerates the truncation); next start after rst deassert is accepted normally.

Verification (CLK_FREQ_HZ=4_000_000, SCCB_FREQ_HZ=100_000, Q=10)
REQ-030 Write 0x12<-0x80, siod_in=0 -> decoded SIOC-high samples 0x42,X,0x12,X,0x80,X; done at T+1141; nack=0.
REQ-031 Same with siod_in=1 throughout -> identical waveform, nack=1 with done; siod_oe=0 during bits 9, 18, 27 exactly.
REQ-032 start pulsed at T+500 during transaction -> ignored; single done at T+1141; busy stays 1 until then.
REQ-033 rst at T+600 -> next cycle sioc=1, siod_out=1, busy=0; no done; new write 0x11<-0x01 completes correctly.
REQ-034 Back-to-back: start held high -> second transaction accepted cycle after done; START q0 SIOD fall occurs with SIOC=1 each time.
REQ-035 Protocol checker over all tests -> SIOD never changes while SIOC=1 except at START/STOP conditions.
